// File: rtl/dbus_arbiter.sv
// Round-robin arbiter sharing the core data bus between the LSU (M0) and an auxiliary master (M1).
// One transaction in flight; abandoned requests are drained and silent slaves are timed out.
module dbus_arbiter #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            m0_ld_req,
  input  logic            m0_st_req,
  input  logic [XLEN-1:0] m0_addr,
  input  logic [XLEN-1:0] m0_w_data,
  input  logic [1:0]      m0_st_ops,
  output logic            m0_ack,
  output logic            m0_err,
  output logic [XLEN-1:0] m0_r_data,
  input  logic            m1_ld_req,
  input  logic            m1_st_req,
  input  logic [XLEN-1:0] m1_addr,
  input  logic [XLEN-1:0] m1_w_data,
  input  logic [1:0]      m1_st_ops,
  output logic            m1_ack,
  output logic            m1_err,
  output logic [XLEN-1:0] m1_r_data,
  output logic            dbus_ld_req,
  output logic            dbus_st_req,
  output logic [XLEN-1:0] dbus_addr,
  output logic [XLEN-1:0] dbus_w_data,
  output logic [1:0]      dbus_st_ops,
  input  logic            dbus_ack,
  input  logic [XLEN-1:0] dbus_r_data,
  output logic            busy_o
);

  localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);
  localparam int CNT_W  = TMO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = TMO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            state_q;
  logic              last_grant_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              dbus_ld_q;
  logic              dbus_st_q;
  logic [XLEN-1:0]   dbus_addr_q;
  logic [XLEN-1:0]   dbus_w_data_q;
  logic [1:0]        dbus_st_ops_q;
  logic              busy_q;

  logic m0_req, m1_req, gnt_req;
  logic grant_d;
  logic tmo_hit;
  logic done_busy;

  assign m0_req  = m0_ld_req | m0_st_req;
  assign m1_req  = m1_ld_req | m1_st_req;
  assign gnt_req = last_grant_q ? m1_req : m0_req;

  // On a tie the master that did not win last time is granted.
  assign grant_d = (m0_req && m1_req) ? ~last_grant_q : m1_req;

  // A coincident dbus_ack takes precedence over the timeout.
  assign tmo_hit   = TMO_EN && (cnt_q == TMO_LAST) && !dbus_ack;
  assign done_busy = (state_q == S_BUSY) && gnt_req && (dbus_ack || tmo_hit);

  assign m0_ack    = done_busy && !last_grant_q;
  assign m1_ack    = done_busy &&  last_grant_q;
  assign m0_err    = m0_ack && !dbus_ack;
  assign m1_err    = m1_ack && !dbus_ack;
  assign m0_r_data = (m0_ack && dbus_ack) ? dbus_r_data : '0;
  assign m1_r_data = (m1_ack && dbus_ack) ? dbus_r_data : '0;

  assign dbus_ld_req = dbus_ld_q;
  assign dbus_st_req = dbus_st_q;
  assign dbus_addr   = dbus_addr_q;
  assign dbus_w_data = dbus_w_data_q;
  assign dbus_st_ops = dbus_st_ops_q;
  assign busy_o      = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      last_grant_q  <= 1'b1;
      cnt_q         <= '0;
      dbus_ld_q     <= 1'b0;
      dbus_st_q     <= 1'b0;
      dbus_addr_q   <= '0;
      dbus_w_data_q <= '0;
      dbus_st_ops_q <= '0;
      busy_q        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (m0_req || m1_req) begin
            state_q       <= S_BUSY;
            busy_q        <= 1'b1;
            last_grant_q  <= grant_d;
            cnt_q         <= '0;
            dbus_ld_q     <= grant_d ? m1_ld_req : m0_ld_req;
            dbus_st_q     <= grant_d ? m1_st_req : m0_st_req;
            dbus_addr_q   <= grant_d ? m1_addr   : m0_addr;
            dbus_w_data_q <= grant_d ? m1_w_data : m0_w_data;
            dbus_st_ops_q <= grant_d ? m1_st_ops : m0_st_ops;
          end
        end
        S_BUSY, S_DRAIN: begin
          if (dbus_ack || tmo_hit) begin
            state_q       <= S_IDLE;
            busy_q        <= 1'b0;
            dbus_ld_q     <= 1'b0;
            dbus_st_q     <= 1'b0;
            dbus_addr_q   <= '0;
            dbus_w_data_q <= '0;
            dbus_st_ops_q <= '0;
          end else begin
            if (TMO_EN) cnt_q <= cnt_q + CNT_W'(1);
            // A flushed master leaves the downstream request running until it resolves.
            if (state_q == S_BUSY && !gnt_req) state_q <= S_DRAIN;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_arbiter.sv
// Directed bench for dbus_arbiter: arbitration, flush drain, timeout, late ack and async reset.
module tb_dbus_arbiter;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            m0_ld_req, m0_st_req, m1_ld_req, m1_st_req;
  logic [XLEN-1:0] m0_addr, m0_w_data, m1_addr, m1_w_data;
  logic [1:0]      m0_st_ops, m1_st_ops;
  logic            m0_ack, m0_err, m1_ack, m1_err;
  logic [XLEN-1:0] m0_r_data, m1_r_data;
  logic            dbus_ld_req, dbus_st_req, dbus_ack;
  logic [XLEN-1:0] dbus_addr, dbus_w_data, dbus_r_data;
  logic [1:0]      dbus_st_ops;
  logic            busy_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dbus_arbiter #(.XLEN(XLEN), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_ld_req(m0_ld_req), .m0_st_req(m0_st_req), .m0_addr(m0_addr),
    .m0_w_data(m0_w_data), .m0_st_ops(m0_st_ops),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_r_data(m0_r_data),
    .m1_ld_req(m1_ld_req), .m1_st_req(m1_st_req), .m1_addr(m1_addr),
    .m1_w_data(m1_w_data), .m1_st_ops(m1_st_ops),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_r_data(m1_r_data),
    .dbus_ld_req(dbus_ld_req), .dbus_st_req(dbus_st_req), .dbus_addr(dbus_addr),
    .dbus_w_data(dbus_w_data), .dbus_st_ops(dbus_st_ops),
    .dbus_ack(dbus_ack), .dbus_r_data(dbus_r_data), .busy_o(busy_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    m0_ld_req = 0; m0_st_req = 0; m0_addr = '0; m0_w_data = '0; m0_st_ops = '0;
    m1_ld_req = 0; m1_st_req = 0; m1_addr = '0; m1_w_data = '0; m1_st_ops = '0;
    dbus_ack = 0; dbus_r_data = '0;

    @(negedge clk);
    chk("rst_ld", dbus_ld_req, 0);
    chk("rst_st", dbus_st_req, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_addr", dbus_addr, 0);
    tick();
    rst_n = 1'b1;

    // Tie from reset: M0 first, then M1
    m0_ld_req = 1; m0_addr = 32'h10;
    m1_st_req = 1; m1_addr = 32'h20; m1_w_data = 32'h1234; m1_st_ops = 2'd2;
    @(negedge clk);
    chk("t2_c0_busy", busy_o, 0);
    tick();
    dbus_ack = 1; dbus_r_data = 32'hA5;
    @(negedge clk);
    chk("t2_c1_ld", dbus_ld_req, 1);
    chk("t2_c1_st", dbus_st_req, 0);
    chk("t2_c1_addr", dbus_addr, 32'h10);
    chk("t2_c1_m0ack", m0_ack, 1);
    chk("t2_c1_m0rd", m0_r_data, 32'hA5);
    chk("t2_c1_m1ack", m1_ack, 0);
    chk("t2_c1_m1rd", m1_r_data, 0);
    tick();
    m0_ld_req = 0; dbus_ack = 0; dbus_r_data = '0;
    @(negedge clk);
    chk("t2_bubble_busy", busy_o, 0);
    chk("t2_bubble_st", dbus_st_req, 0);
    tick();
    dbus_ack = 1; dbus_r_data = 32'h77;
    @(negedge clk);
    chk("t2_m1_st", dbus_st_req, 1);
    chk("t2_m1_addr", dbus_addr, 32'h20);
    chk("t2_m1_wd", dbus_w_data, 32'h1234);
    chk("t2_m1_ops", dbus_st_ops, 2);
    chk("t2_m1_ack", m1_ack, 1);
    chk("t2_m1_rd", m1_r_data, 32'h77);
    chk("t2_m1_m0ack", m0_ack, 0);
    tick();
    m1_st_req = 0; m1_st_ops = '0; dbus_ack = 0; dbus_r_data = '0;
    @(negedge clk);
    chk("t2_end_busy", busy_o, 0);
    tick();

    // M0 load alone, ack two cycles after grant
    m0_ld_req = 1; m0_addr = 32'h100;
    @(negedge clk);
    chk("t1_c0_ld", dbus_ld_req, 0);
    tick();
    @(negedge clk);
    chk("t1_c1_ld", dbus_ld_req, 1);
    chk("t1_c1_addr", dbus_addr, 32'h100);
    chk("t1_c1_ack", m0_ack, 0);
    tick();
    dbus_r_data = 32'h1111;
    @(negedge clk);
    chk("t1_c2_ld", dbus_ld_req, 1);
    chk("t1_c2_ack", m0_ack, 0);
    chk("t1_c2_rd0", m0_r_data, 0);
    tick();
    dbus_ack = 1; dbus_r_data = 32'hDEADBEEF;
    @(negedge clk);
    chk("t1_c3_ld", dbus_ld_req, 1);
    chk("t1_c3_ack", m0_ack, 1);
    chk("t1_c3_err", m0_err, 0);
    chk("t1_c3_rd", m0_r_data, 32'hDEADBEEF);
    chk("t1_c3_m1ack", m1_ack, 0);
    tick();
    m0_ld_req = 0; dbus_ack = 0; dbus_r_data = '0;
    @(negedge clk);
    chk("t1_c4_ld", dbus_ld_req, 0);
    chk("t1_c4_busy", busy_o, 0);
    tick();

    // M0 store flushed mid-transaction -> drain
    m0_st_req = 1; m0_addr = 32'h200; m0_w_data = 32'h55AA; m0_st_ops = 2'd2;
    tick();
    @(negedge clk);
    chk("t3_c1_st", dbus_st_req, 1);
    chk("t3_c1_addr", dbus_addr, 32'h200);
    chk("t3_c1_wd", dbus_w_data, 32'h55AA);
    chk("t3_c1_ops", dbus_st_ops, 2);
    tick();
    m0_st_req = 0;
    @(negedge clk);
    chk("t3_c2_st", dbus_st_req, 1);
    chk("t3_c2_ack", m0_ack, 0);
    tick();
    dbus_ack = 1; dbus_r_data = 32'h99;
    @(negedge clk);
    chk("t3_drain_st", dbus_st_req, 1);
    chk("t3_drain_busy", busy_o, 1);
    chk("t3_drain_ack", m0_ack, 0);
    chk("t3_drain_rd", m0_r_data, 0);
    tick();
    // Late ack while idle is ignored
    @(negedge clk);
    chk("t3_idle_st", dbus_st_req, 0);
    chk("t3_idle_busy", busy_o, 0);
    chk("late_ack_m0", m0_ack, 0);
    tick();
    dbus_ack = 0; dbus_r_data = '0;
    @(negedge clk);
    chk("late_ack_busy", busy_o, 0);
    tick();

    // M1 load, slave never acks -> timeout on 4th busy cycle
    m1_ld_req = 1; m1_addr = 32'h300; dbus_r_data = 32'hFFFFFFFF;
    tick();
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk($sformatf("t4_c%0d_ack", i), m1_ack, 0);
      chk($sformatf("t4_c%0d_ld", i), dbus_ld_req, 1);
      tick();
    end
    @(negedge clk);
    chk("t4_tmo_ack", m1_ack, 1);
    chk("t4_tmo_err", m1_err, 1);
    chk("t4_tmo_rd", m1_r_data, 0);
    chk("t4_tmo_m0ack", m0_ack, 0);
    tick();
    m1_ld_req = 0; dbus_r_data = '0;
    @(negedge clk);
    chk("t4_after_ld", dbus_ld_req, 0);
    chk("t4_after_busy", busy_o, 0);
    tick();

    // Ack coincident with the timeout cycle wins
    m1_ld_req = 1; m1_addr = 32'h304;
    tick();
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk($sformatf("t5_c%0d_ack", i), m1_ack, 0);
      tick();
    end
    dbus_ack = 1; dbus_r_data = 32'hCAFE0005;
    @(negedge clk);
    chk("t5_ack", m1_ack, 1);
    chk("t5_err", m1_err, 0);
    chk("t5_rd", m1_r_data, 32'hCAFE0005);
    tick();
    m1_ld_req = 0; dbus_ack = 0; dbus_r_data = '0;
    @(negedge clk);
    chk("t5_after_ld", dbus_ld_req, 0);
    tick();

    // Async reset during BUSY; afterwards M0 wins the tie again
    m0_ld_req = 1; m0_addr = 32'h400;
    tick();
    @(negedge clk);
    chk("t6_busy_ld", dbus_ld_req, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_ld", dbus_ld_req, 0);
    chk("t6_rst_busy", busy_o, 0);
    chk("t6_rst_addr", dbus_addr, 0);
    m0_ld_req = 0;
    tick();
    rst_n = 1'b1;
    m0_ld_req = 1; m0_addr = 32'h500;
    m1_ld_req = 1; m1_addr = 32'h600;
    @(negedge clk);
    chk("t6_c0_busy", busy_o, 0);
    tick();
    dbus_ack = 1; dbus_r_data = 32'h5;
    @(negedge clk);
    chk("t6_tie_addr", dbus_addr, 32'h500);
    chk("t6_tie_m0ack", m0_ack, 1);
    chk("t6_tie_m1ack", m1_ack, 0);
    tick();
    m0_ld_req = 0; m1_ld_req = 0; dbus_ack = 0; dbus_r_data = '0;
    @(negedge clk);
    chk("t6_end_busy", busy_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
